// File: rtl/req2send_pkg.sv
// Shared types, latency bounds and the ack-latency helper for the
// req_data/ready/done responder and its ack channel.
package req2send_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RDY  = 2'd1,
        WAIT_DONE = 2'd2
    } xfer_state_e;

    localparam int READY_MIN = 1;
    localparam int READY_MAX = 3;
    localparam int DONE_MIN  = 1;
    localparam int DONE_MAX  = 5;
    localparam int ACK_MIN   = 1;
    localparam int ACK_MAX   = 255;

    // min(nominal, bound) with both treated as unsigned, clipped to what a
    // cw-bit counter can hold, and never below one cycle.
    function automatic int sat_lat(input int nominal, input int bound, input int cw);
        int unsigned n;
        int unsigned b;
        int unsigned m;
        int unsigned cap;
        n   = unsigned'(nominal);
        b   = unsigned'(bound);
        m   = (n < b) ? n : b;
        cap = (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
        if (m > cap) begin
            m = cap;
        end
        if (m == 32'd0) begin
            m = 32'd1;
        end
        return int'(m);
    endfunction

endpackage

// File: rtl/req2send_responder_if.sv
// Transfer and ack handshake bundle between a checker (master) and the
// responder (slave).
interface req2send_responder_if #(
    parameter int DW = 16
);
    logic          req_data;
    logic [DW-1:0] data;
    logic          req;
    logic [31:0]   max_count;
    logic          ready;
    logic [DW-1:0] d;
    logic          done;
    logic [DW-1:0] q;
    logic          ack;
    logic          busy;
    logic          drop_err;

    modport master (
        output req_data, data, req, max_count,
        input  ready, d, done, q, ack, busy, drop_err
    );

    modport slave (
        input  req_data, data, req, max_count,
        output ready, d, done, q, ack, busy, drop_err
    );
endinterface

// File: rtl/req_ack_timer.sv
// Ack channel: one ack pulse a bounded number of cycles after each rise of
// req; a fresh rise while pending restarts the count.
module req_ack_timer
    import req2send_pkg::*;
#(
    parameter int ACK_LAT = 4,
    parameter int CW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] max_count,
    output logic        ack
);

    logic          req_q_reg;
    logic [CW-1:0] acnt_reg;
    logic          ack_reg;
    logic [CW-1:0] lat;
    logic          rise_rq;

    assign rise_rq = req & ~req_q_reg;

    always_comb begin
        lat = CW'(sat_lat(ACK_LAT, max_count, CW));
    end

    // acnt == 0 means idle; a rise wins over a due ack so a retrigger
    // never produces two pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q_reg <= 1'b0;
            acnt_reg  <= '0;
            ack_reg   <= 1'b0;
        end else begin
            req_q_reg <= req;
            ack_reg   <= 1'b0;
            if (rise_rq) begin
                acnt_reg <= lat;
            end else if (acnt_reg == CW'(1)) begin
                ack_reg  <= 1'b1;
                acnt_reg <= '0;
            end else if (acnt_reg != '0) begin
                acnt_reg <= acnt_reg - CW'(1);
            end
        end
    end

    assign ack = ack_reg;

endmodule

// File: rtl/req2send_responder.sv
// Responder for the req_data/ready/done transfer handshake plus an
// independent req/ack channel.
module req2send_responder
    import req2send_pkg::*;
#(
    parameter int DW        = 16,
    parameter int READY_LAT = 2,
    parameter int DONE_LAT  = 3,
    parameter int ACK_LAT   = 4,
    parameter int CW        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    req2send_responder_if.slave  bus
);

    if (READY_LAT < READY_MIN || READY_LAT > READY_MAX) begin : g_bad_ready_lat
        $error("req2send_responder: READY_LAT out of range");
    end
    if (DONE_LAT < DONE_MIN || DONE_LAT > DONE_MAX) begin : g_bad_done_lat
        $error("req2send_responder: DONE_LAT out of range");
    end
    if (ACK_LAT < ACK_MIN || ACK_LAT > ACK_MAX) begin : g_bad_ack_lat
        $error("req2send_responder: ACK_LAT out of range");
    end

    localparam logic [CW-1:0] RDY_LOAD  = CW'(READY_LAT - 1);
    localparam logic [CW-1:0] DONE_LOAD = CW'(DONE_LAT - 1);

    xfer_state_e   state_reg;
    logic [CW-1:0] cnt_reg;
    logic [DW-1:0] v1_reg;
    logic [DW-1:0] v2_reg;
    logic [DW-1:0] d_reg;
    logic [DW-1:0] q_reg;
    logic          ready_reg;
    logic          done_reg;
    logic          busy_reg;
    logic          drop_reg;
    logic          req_data_q_reg;
    logic          rise_rd;

    assign rise_rd = bus.req_data & ~req_data_q_reg;

    // A rise seen while not IDLE (including the done cycle) is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            v1_reg         <= '0;
            v2_reg         <= '0;
            d_reg          <= '0;
            q_reg          <= '0;
            ready_reg      <= 1'b0;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            drop_reg       <= 1'b0;
            req_data_q_reg <= 1'b0;
        end else begin
            req_data_q_reg <= bus.req_data;
            ready_reg      <= 1'b0;
            done_reg       <= 1'b0;
            if (rise_rd && state_reg != IDLE) begin
                drop_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (rise_rd) begin
                        v1_reg    <= bus.data;
                        cnt_reg   <= RDY_LOAD;
                        state_reg <= WAIT_RDY;
                        busy_reg  <= 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (cnt_reg == '0) begin
                        ready_reg <= 1'b1;
                        d_reg     <= v1_reg;
                        v2_reg    <= bus.data;
                        cnt_reg   <= DONE_LOAD;
                        state_reg <= WAIT_DONE;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (cnt_reg == '0) begin
                        done_reg  <= 1'b1;
                        q_reg     <= v2_reg;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready    = ready_reg;
    assign bus.d        = d_reg;
    assign bus.done     = done_reg;
    assign bus.q        = q_reg;
    assign bus.busy     = busy_reg;
    assign bus.drop_err = drop_reg;

    req_ack_timer #(
        .ACK_LAT (ACK_LAT),
        .CW      (CW)
    ) u_ack_timer (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req),
        .max_count (bus.max_count),
        .ack       (bus.ack)
    );

endmodule

// File: tb/tb_req2send_responder.sv
// Directed and random stimulus for req2send_responder, checked every cycle
// against a schedule-based model of the transfer and ack timing.
module tb_req2send_responder;

    localparam int DW        = 16;
    localparam int READY_LAT = 2;
    localparam int DONE_LAT  = 3;
    localparam int ACK_LAT   = 4;
    localparam int CW        = 8;

    logic clk;
    logic rst;

    req2send_responder_if #(.DW(DW)) bus ();

    req2send_responder #(
        .DW        (DW),
        .READY_LAT (READY_LAT),
        .DONE_LAT  (DONE_LAT),
        .ACK_LAT   (ACK_LAT),
        .CW        (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: each accepted transfer is a pair of scheduled edge numbers.
    longint     edge_n   = 0;
    longint     ready_at = -1;
    longint     done_at  = -1;
    longint     ack_at   = -1;
    logic [15:0] m_v1 = '0;
    logic [15:0] m_v2 = '0;
    logic [15:0] m_d  = '0;
    logic [15:0] m_q  = '0;
    bit         m_drop  = 0;
    bit         prev_rd = 0;
    bit         prev_rq = 0;
    bit         exp_ready, exp_done, exp_ack, exp_busy;

    task automatic model_edge(input bit r, input bit rd, input logic [15:0] dat,
                              input bit rq, input logic [31:0] mc);
        longint lat;
        edge_n++;
        exp_ready = 0;
        exp_done  = 0;
        exp_ack   = 0;
        if (r) begin
            ready_at = -1;
            done_at  = -1;
            ack_at   = -1;
            m_d      = '0;
            m_q      = '0;
            m_drop   = 0;
            prev_rd  = 0;
            prev_rq  = 0;
            exp_busy = 0;
            return;
        end
        if (rd && !prev_rd) begin
            if (edge_n > done_at) begin
                m_v1     = dat;
                ready_at = edge_n + READY_LAT;
                done_at  = ready_at + DONE_LAT;
            end else begin
                m_drop = 1;
            end
        end
        prev_rd = rd;
        if (edge_n == ready_at) begin
            exp_ready = 1;
            m_d       = m_v1;
            m_v2      = dat;
        end
        if (edge_n == done_at) begin
            exp_done = 1;
            m_q      = m_v2;
        end
        exp_busy = (edge_n < done_at);
        if (rq && !prev_rq) begin
            lat = longint'(mc);
            if (lat > ACK_LAT) lat = ACK_LAT;
            if (lat > 255) lat = 255;
            if (lat < 1) lat = 1;
            ack_at = edge_n + lat;
        end else if (edge_n == ack_at) begin
            exp_ack = 1;
        end
        prev_rq = rq;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit rd, input logic [15:0] dat,
                       input bit rq, input logic [31:0] mc);
        rst           = r;
        bus.req_data  = rd;
        bus.data      = dat;
        bus.req       = rq;
        bus.max_count = mc;
        @(posedge clk);
        model_edge(r, rd, dat, rq, mc);
        #1;
        check("ready",    32'(bus.ready),    32'(exp_ready));
        check("d",        32'(bus.d),        32'(m_d));
        check("done",     32'(bus.done),     32'(exp_done));
        check("q",        32'(bus.q),        32'(m_q));
        check("ack",      32'(bus.ack),      32'(exp_ack));
        check("busy",     32'(bus.busy),     32'(exp_busy));
        check("drop_err", 32'(bus.drop_err), 32'(m_drop));
        $display("edge %0d rst=%0b rd=%0b data=%h rq=%0b mc=%0d | rdy=%0b d=%h done=%0b q=%h ack=%0b busy=%0b drop=%0b",
                 edge_n, r, rd, dat, rq, mc, bus.ready, bus.d, bus.done, bus.q,
                 bus.ack, bus.busy, bus.drop_err);
    endtask

    function automatic logic [15:0] rnd16();
        return 16'($urandom());
    endfunction

    initial begin
        logic [31:0] mc_tab [9];
        mc_tab = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd10, 32'd300, 32'hFFFF_FFFF};

        // Reset
        cyc(1, 0, 16'h0000, 0, 10);
        cyc(1, 0, 16'h0000, 0, 10);

        // Single transfer: A5A5 at the rise, 5A5A in the ready cycle
        cyc(0, 1, 16'hA5A5, 0, 10);
        cyc(0, 1, rnd16(),  0, 10);
        cyc(0, 0, 16'h5A5A, 0, 10);
        for (int i = 0; i < 6; i++) cyc(0, 0, rnd16(), 0, 10);

        // Overlap: second rise three cycles in is dropped
        cyc(0, 1, 16'h1111, 0, 10);
        cyc(0, 0, rnd16(),  0, 10);
        cyc(0, 0, 16'h2222, 0, 10);
        cyc(0, 1, 16'h3333, 0, 10);
        for (int i = 0; i < 6; i++) cyc(0, 0, rnd16(), 0, 10);

        // Clear drop_err, then back-to-back with a rise in the done cycle
        cyc(1, 0, 16'h0000, 0, 10);
        cyc(0, 1, 16'h4444, 0, 10);
        cyc(0, 0, rnd16(),  0, 10);
        cyc(0, 0, 16'h5555, 0, 10);
        for (int i = 0; i < 3; i++) cyc(0, 0, rnd16(), 0, 10);
        cyc(0, 1, 16'h6666, 0, 10);
        cyc(0, 0, rnd16(),  0, 10);
        cyc(0, 0, 16'h7777, 0, 10);
        for (int i = 0; i < 6; i++) cyc(0, 0, rnd16(), 0, 10);
        // Rise exactly in the done cycle (edge 5 of the transfer) is dropped
        cyc(0, 1, 16'h8888, 0, 10);
        for (int i = 0; i < 4; i++) cyc(0, 0, rnd16(), 0, 10);
        cyc(0, 1, 16'h9999, 0, 10);
        for (int i = 0; i < 6; i++) cyc(0, 0, rnd16(), 0, 10);

        // Ack bound: max_count 10, 2, 0
        cyc(0, 0, 16'h0, 1, 10);
        for (int i = 0; i < 7; i++) cyc(0, 0, 16'h0, 0, 10);
        cyc(0, 0, 16'h0, 1, 2);
        for (int i = 0; i < 7; i++) cyc(0, 0, 16'h0, 0, 2);
        cyc(0, 0, 16'h0, 1, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 16'h0, 0, 0);

        // Ack retrigger
        cyc(0, 0, 16'h0, 1, 10);
        cyc(0, 0, 16'h0, 0, 10);
        cyc(0, 0, 16'h0, 1, 10);
        for (int i = 0; i < 8; i++) cyc(0, 0, 16'h0, 0, 10);

        // Reset in WAIT_DONE with req_data and a pending ack held through it
        cyc(0, 1, 16'hBEEF, 1, 10);
        for (int i = 0; i < 3; i++) cyc(0, 1, rnd16(), 1, 10);
        cyc(1, 1, rnd16(), 1, 10);
        cyc(1, 1, rnd16(), 1, 10);
        cyc(0, 1, 16'hCAFE, 1, 10);
        for (int i = 0; i < 7; i++) cyc(0, 1, rnd16(), 0, 10);
        cyc(0, 0, rnd16(), 0, 10);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), rnd16(),
                ($urandom_range(0, 4) == 0), mc_tab[$urandom_range(0, 8)]);
        end
        for (int i = 0; i < 12; i++) cyc(0, 0, rnd16(), 0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
